// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD family of engines.
// Holds the FSM state encoding and the default operand/counter widths.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int GCD_WIDTH = 8;
    localparam int GCD_CNT_W = GCD_WIDTH;

endpackage

// File: rtl/gcd_sub_cmp.sv
// Compare-and-subtract step for Euclid's algorithm.
// Reports ordering of a and b and the non-negative difference larger minus smaller.
module gcd_sub_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic [WIDTH-1:0] diff
);

    assign a_gt_b = (a > b);
    assign a_eq_b = (a == b);
    assign diff   = a_gt_b ? (a - b) : (b - a);

endmodule

// File: rtl/gcd_seq_engine.sv
// Multi-cycle GCD engine: one Euclid subtraction per clock, valid/ready on both sides.
// Reports the result, a saturating iteration count and a both-operands-zero flag.
module gcd_seq_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int CNT_W = GCD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [CNT_W-1:0] out_iter,
    output logic             out_zero,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ITER_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] iter_reg;

    logic             a_gt_b;
    logic             a_eq_b;
    logic [WIDTH-1:0] diff;

    gcd_sub_cmp #(
        .WIDTH (WIDTH)
    ) u_sub_cmp (
        .a      (a_reg),
        .b      (b_reg),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .diff   (diff)
    );

    assign in_ready = (state == IDLE);

    // out_valid is a registered view of DONE, so it rises one cycle after entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            iter_reg  <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_iter  <= '0;
            out_zero  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= in_a;
                        b_reg    <= in_b;
                        iter_reg <= '0;
                        busy     <= 1'b1;
                        if ((in_a == '0) || (in_b == '0)) begin
                            out_gcd  <= in_a | in_b;
                            out_iter <= '0;
                            out_zero <= (in_a == '0) && (in_b == '0);
                            state    <= DONE;
                        end else begin
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (a_eq_b) begin
                        out_gcd  <= a_reg;
                        out_iter <= iter_reg;
                        out_zero <= 1'b0;
                        state    <= DONE;
                    end else begin
                        if (a_gt_b) begin
                            a_reg <= diff;
                        end else begin
                            b_reg <= diff;
                        end
                        if (iter_reg != ITER_MAX) begin
                            iter_reg <= iter_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_seq_engine.sv
// Directed bench for gcd_seq_engine: an 8-bit-counter instance and a 4-bit-counter
// instance share stimulus; sel chooses which one a transaction targets.
module tb_gcd_seq_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       out_ready = 1'b0;
    logic       sel = 1'b0;

    logic       in_ready8, out_valid8, out_zero8, busy8;
    logic [7:0] out_gcd8, out_iter8;
    logic       in_ready4, out_valid4, out_zero4, busy4;
    logic [7:0] out_gcd4;
    logic [3:0] out_iter4;

    logic       cur_in_ready, cur_out_valid, cur_out_zero, cur_busy;
    logic [7:0] cur_out_gcd, cur_out_iter;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gcd_seq_engine #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (in_ready8),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid8),
        .out_ready (out_ready),
        .out_gcd   (out_gcd8),
        .out_iter  (out_iter8),
        .out_zero  (out_zero8),
        .busy      (busy8)
    );

    gcd_seq_engine #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & sel),
        .in_ready  (in_ready4),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .out_gcd   (out_gcd4),
        .out_iter  (out_iter4),
        .out_zero  (out_zero4),
        .busy      (busy4)
    );

    assign cur_in_ready  = sel ? in_ready4  : in_ready8;
    assign cur_out_valid = sel ? out_valid4 : out_valid8;
    assign cur_out_zero  = sel ? out_zero4  : out_zero8;
    assign cur_busy      = sel ? busy4      : busy8;
    assign cur_out_gcd   = sel ? out_gcd4   : out_gcd8;
    assign cur_out_iter  = sel ? {4'd0, out_iter4} : out_iter8;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, measure latency, optionally hold off the consumer
    // and spam in_valid with other operands while busy, then complete the handshake.
    task automatic run_op(input string name, input logic use4,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_gcd, input logic [7:0] exp_iter,
                          input logic exp_zero, input int exp_lat,
                          input int hold, input logic spam);
        int lat;
        lat = -1;
        sel = use4;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n_checks++;
        if (cur_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, cur_in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (spam) begin
                in_valid = 1'b1;
                in_a = 8'd99;
                in_b = 8'd33;
            end
            step();
            if (cur_out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        for (int h = 0; h <= hold; h++) begin
            n_checks++;
            if (cur_out_gcd !== exp_gcd || cur_out_iter !== exp_iter ||
                cur_out_zero !== exp_zero || cur_out_valid !== 1'b1 ||
                cur_in_ready !== 1'b0 || cur_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s result[%0d]: got gcd=%0d iter=%0d zero=%b valid=%b rdy=%b busy=%b want gcd=%0d iter=%0d zero=%b valid=1 rdy=0 busy=1",
                         name, h, cur_out_gcd, cur_out_iter, cur_out_zero, cur_out_valid,
                         cur_in_ready, cur_busy, exp_gcd, exp_iter, exp_zero);
            end
            if (h < hold) step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (cur_out_valid !== 1'b0 || cur_in_ready !== 1'b1 || cur_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after handshake: got valid=%b rdy=%b busy=%b want valid=0 rdy=1 busy=0",
                     name, cur_out_valid, cur_in_ready, cur_busy);
        end
        $display("txn %s: a=%0d b=%0d gcd=%0d iter=%0d zero=%b lat=%0d", name, a, b,
                 exp_gcd, exp_iter, exp_zero, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++;
        if (out_valid8 !== 1'b0 || out_gcd8 !== 8'd0 || out_iter8 !== 8'd0 ||
            out_zero8 !== 1'b0 || busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b gcd=%0d iter=%0d zero=%b busy=%b rdy=%b want 0 0 0 0 0 1",
                     out_valid8, out_gcd8, out_iter8, out_zero8, busy8, in_ready8);
        end
        rst_n = 1'b1;
        step();
        $display("txn reset: released");
    endtask

    task automatic test_basic();
        run_op("12_8",  1'b0, 8'd12, 8'd8,  8'd4,  8'd2, 1'b0, 4, 0, 1'b0);
        run_op("8_12",  1'b0, 8'd8,  8'd12, 8'd4,  8'd2, 1'b0, 4, 0, 1'b0);
        run_op("15_15", 1'b0, 8'd15, 8'd15, 8'd15, 8'd0, 1'b0, 2, 0, 1'b0);
    endtask

    task automatic test_zero();
        run_op("0_9", 1'b0, 8'd0, 8'd9, 8'd9, 8'd0, 1'b0, 1, 0, 1'b0);
        run_op("9_0", 1'b0, 8'd9, 8'd0, 8'd9, 8'd0, 1'b0, 1, 0, 1'b0);
        run_op("0_0", 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1, 0, 1'b0);
    endtask

    task automatic test_worst_case();
        run_op("255_1",      1'b0, 8'd255, 8'd1, 8'd1, 8'd254, 1'b0, 256, 0, 1'b0);
        run_op("255_1_sat",  1'b1, 8'd255, 8'd1, 8'd1, 8'd15,  1'b0, 256, 0, 1'b0);
        run_op("21_14_cnt4", 1'b1, 8'd21,  8'd14, 8'd7, 8'd2,  1'b0, 4,   0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op("bp_12_8", 1'b0, 8'd12, 8'd8, 8'd4, 8'd2, 1'b0, 4, 5, 1'b1);
        run_op("bp_after", 1'b0, 8'd36, 8'd24, 8'd12, 8'd2, 1'b0, 4, 0, 1'b0);
    endtask

    task automatic test_abort();
        int seen;
        seen = 0;
        sel = 1'b0;
        in_a = 8'd200;
        in_b = 8'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        n_checks++;
        if (busy8 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort busy_mid_calc: got %b want 1", busy8);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort async_reset: got valid=%b busy=%b rdy=%b want 0 0 1",
                     out_valid8, busy8, in_ready8);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            if (out_valid8 === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort no_valid: got %0d valid cycles want 0", seen);
        end
        $display("txn abort: 200_3 reset mid-CALC");
        run_op("21_14", 1'b0, 8'd21, 8'd14, 8'd7, 8'd2, 1'b0, 4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_worst_case();
        test_backpressure();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
